// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters with registered, zero-skew sync/blank/coord/strobe decode.
// Optional build macro VGA_TIMING_CE_EN adds the pix_ce advance enable.
module vga_timing_gen #(
    parameter int unsigned CW       = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef VGA_TIMING_CE_EN
    input  logic          pix_ce,
`endif
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_end,
    output logic          frame_start
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_adv;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_active;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_line_end;
    logic          w_frame_start;

    logic [CW-1:0] r_h_count;
    logic [CW-1:0] r_v_count;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_end;
    logic          r_frame_start;

`ifdef VGA_TIMING_CE_EN
    assign w_adv = pix_ce;
`else
    assign w_adv = 1'b1;
`endif

    // ST_IDLE is the post-reset state; its first advance presents pixel (0,0) rather than (1,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_count;
        w_v_nxt     = r_v_count;
        if (w_adv) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RUN;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                end
                ST_RUN: begin
                    if (r_h_count == CW'(H_TOTAL - 1)) begin
                        w_h_nxt = '0;
                        w_v_nxt = (r_v_count == CW'(V_TOTAL - 1)) ? '0 : r_v_count + CW'(1);
                    end else begin
                        w_h_nxt = r_h_count + CW'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Decode from next-state counters so registered outputs line up with the registered counters.
    always_comb begin
        w_active      = (w_h_nxt < CW'(H_ACTIVE)) && (w_v_nxt < CW'(V_ACTIVE));
        w_hs_on       = (w_h_nxt >= CW'(HS_START)) && (w_h_nxt < CW'(HS_END));
        w_vs_on       = (w_v_nxt >= CW'(VS_START)) && (w_v_nxt < CW'(VS_END));
        w_line_end    = (w_h_nxt == CW'(H_TOTAL - 1));
        w_frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_active      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_adv) begin
            r_h_count     <= w_h_nxt;
            r_v_count     <= w_v_nxt;
            r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
            r_active      <= w_active;
            r_x           <= w_active ? w_h_nxt : '0;
            r_y           <= w_active ? w_v_nxt : '0;
            r_line_end    <= w_line_end;
            r_frame_start <= w_frame_start;
        end
    end

    assign h_count     = r_h_count;
    assign v_count     = r_v_count;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign x           = r_x;
    assign y           = r_y;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every cycle against a pixel-index reference model.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_CE_EN
    localparam bit CE_EN = 1'b1;
`else
    localparam bit CE_EN = 1'b0;
`endif
    localparam int NDUT = 3;
    localparam int HA[NDUT] = '{640, 640, 8};
    localparam int HF[NDUT] = '{16, 16, 2};
    localparam int HS[NDUT] = '{96, 96, 2};
    localparam int HB[NDUT] = '{48, 48, 2};
    localparam int VA[NDUT] = '{480, 6, 4};
    localparam int VF[NDUT] = '{10, 2, 1};
    localparam int VS[NDUT] = '{2, 2, 1};
    localparam int VB[NDUT] = '{33, 3, 1};
    localparam bit HP[NDUT] = '{1'b0, 1'b0, 1'b1};
    localparam bit VP[NDUT] = '{1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_ce;
    logic [44:0] obs [NDUT];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          run [NDUT];
    int          pix [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [9:0] h_count, v_count, x, y;
        logic       hsync, vsync, active, line_end, frame_start;
        vga_timing_gen #(
            .CW(10),
            .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
            .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
            .HS_POL(HP[g]), .VS_POL(VP[g])
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
`ifdef VGA_TIMING_CE_EN
            .pix_ce(pix_ce),
`endif
            .h_count(h_count),
            .v_count(v_count),
            .hsync(hsync),
            .vsync(vsync),
            .active(active),
            .x(x),
            .y(y),
            .line_end(line_end),
            .frame_start(frame_start)
        );
        assign obs[g] = {h_count, v_count, hsync, vsync, active, x, y, line_end, frame_start};
    end

    function automatic int frame_len(input int i);
        return (HA[i] + HF[i] + HS[i] + HB[i]) * (VA[i] + VF[i] + VS[i] + VB[i]);
    endfunction

    // Expected outputs from the linear pixel index within the frame.
    function automatic logic [44:0] model(input int i, input bit running, input int p);
        int   ht;
        int   h;
        int   v;
        logic act;
        logic hs;
        logic vs;
        if (!running) return {10'd0, 10'd0, ~HP[i], ~VP[i], 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        ht  = HA[i] + HF[i] + HS[i] + HB[i];
        h   = p % ht;
        v   = p / ht;
        act = (h < HA[i]) && (v < VA[i]);
        hs  = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
        vs  = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
        return {10'(h), 10'(v), hs, vs, act, act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0,
                1'(h == ht - 1), 1'(p == 0)};
    endfunction

    task automatic check_all();
        logic [44:0] exp_v;
        for (int i = 0; i < NDUT; i++) begin
            exp_v = model(i, run[i], pix[i]);
            checks++;
            assert (obs[i] === exp_v) else begin
                errors++;
                $error("FAIL dut%0d cyc=%0d observed=%h expected=%h", i, cyc, obs[i], exp_v);
            end
        end
    endtask

    task automatic cycle(input bit rst_val);
        @(negedge clk);
        rst_n  = rst_val;
        pix_ce = ($urandom_range(0, 3) == 0);
        if (!rst_val) for (int i = 0; i < NDUT; i++) run[i] = 1'b0;
        @(posedge clk);
        if (rst_n && (pix_ce || !CE_EN)) begin
            for (int i = 0; i < NDUT; i++) begin
                if (!run[i]) begin
                    run[i] = 1'b1;
                    pix[i] = 0;
                end else begin
                    pix[i] = (pix[i] + 1) % frame_len(i);
                end
            end
        end
        #1;
        check_all();
        cyc++;
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            run[i] = 1'b0;
            pix[i] = 0;
        end
        repeat (3) cycle(1'b0);
        repeat (20000) cycle(1'b1);
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(500, 8000)) cycle(1'b1);
            // Asynchronous assertion between edges must clear outputs without a clock.
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            for (int i = 0; i < NDUT; i++) run[i] = 1'b0;
            #1;
            check_all();
            repeat (3) cycle(1'b0);
            repeat (8000) cycle(1'b1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
